// File: rtl/fp_pkg.sv
// fp_pkg: shared single-precision constants, the field view of an IEEE-754
// word, the accumulator state encoding and small classification helpers.
// Imported by fp_adder, fp_accumulator and fp_accumulator_if.
package fp_pkg;

  localparam int FP_EXP_W   = 8;
  localparam int FP_MAN_W   = 23;
  localparam int FP_BIAS    = 127;
  // All-ones exponent marks inf/NaN
  localparam int FP_EXP_MAX = 2 * FP_BIAS + 1;

  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_e;

  // True for any NaN encoding (quiet or signalling)
  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'(FP_EXP_MAX)) && (x[22:0] != 23'd0);
  endfunction

  // Leading-zero count of a 24-bit significand; 24 when the input is zero
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) n = 5'(23 - i);
      else      n = n;
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_accumulator_if.sv
// fp_accumulator_if: product-in / sum-out handshake bundle.
//   in_valid/in_ready/in_data/in_last : beat stream from the multiplier
//   out_valid/out_ready/out_data/out_count : held vector-sum result
// master = producer/consumer side (bench or neighbouring blocks), slave = accumulator.
interface fp_accumulator_if #(
  parameter int COUNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_data;
  logic [COUNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/fp_adder.sv
// fp_adder: combinational single-precision adder.
//   a, b : IEEE-754 operands
//   sum  : a + b with denormals flushed to signed zero, operand alignment by
//          truncating right shift, round toward zero, canonical NaN for any
//          NaN input or inf - inf.
module fp_adder
  import fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  fp32_t       fa_s, fb_s, big_s, small_s;
  logic        a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic [7:0]  shift_s;
  logic [24:0] mant_big_s, mant_small_s, raw_s;
  logic [4:0]  lz_s;
  logic [9:0]  exp_s;
  logic [22:0] man_s;
  logic        ovf_s, unf_s;

  // Classify operands; an exponent of zero (zero or denormal) counts as zero
  always_comb begin
    fa_s     = fp32_t'(a);
    fb_s     = fp32_t'(b);
    a_zero_s = (fa_s.exp == 8'd0);
    b_zero_s = (fb_s.exp == 8'd0);
    a_inf_s  = (fa_s.exp == 8'(FP_EXP_MAX)) && (fa_s.man == 23'd0);
    b_inf_s  = (fb_s.exp == 8'(FP_EXP_MAX)) && (fb_s.man == 23'd0);
    a_nan_s  = is_nan(a);
    b_nan_s  = is_nan(b);
  end

  // Align the smaller magnitude, add or subtract, then normalise
  always_comb begin
    if (a[30:0] >= b[30:0]) begin
      big_s   = fa_s;
      small_s = fb_s;
    end else begin
      big_s   = fb_s;
      small_s = fa_s;
    end
    shift_s    = big_s.exp - small_s.exp;
    mant_big_s = {2'b01, big_s.man};
    // Bits shifted out are simply dropped; a large shift leaves nothing
    if (shift_s >= 8'd25) mant_small_s = 25'd0;
    else                  mant_small_s = {2'b01, small_s.man} >> shift_s;
    // big has the larger magnitude, so the difference never goes negative
    if (big_s.sign == small_s.sign) raw_s = mant_big_s + mant_small_s;
    else                            raw_s = mant_big_s - mant_small_s;
    lz_s = lzc24(raw_s[23:0]);
    if (raw_s[24]) begin
      man_s = raw_s[23:1];
      exp_s = {2'b00, big_s.exp} + 10'd1;
    end else begin
      // After the shift the hidden one sits at bit 23 and is discarded
      man_s = raw_s[22:0] << lz_s;
      exp_s = {2'b00, big_s.exp} - {5'd0, lz_s};
    end
    ovf_s = !exp_s[9] && (exp_s >= 10'd255);
    unf_s = exp_s[9] || (exp_s == 10'd0);
  end

  // Result selection: specials first, then zero operands, then the normal path
  always_comb begin
    if (a_nan_s || b_nan_s) begin
      sum = FP_QNAN;
    end else if (a_inf_s && b_inf_s) begin
      if (fa_s.sign == fb_s.sign) sum = a;
      else                        sum = FP_QNAN;
    end else if (a_inf_s) begin
      sum = a;
    end else if (b_inf_s) begin
      sum = b;
    end else if (a_zero_s && b_zero_s) begin
      sum = {fa_s.sign & fb_s.sign, 31'd0};
    end else if (a_zero_s) begin
      sum = b;
    end else if (b_zero_s) begin
      sum = a;
    end else if (raw_s == 25'd0) begin
      sum = FP_POS_ZERO;
    end else if (ovf_s) begin
      sum = {big_s.sign, FP_POS_INF[30:0]};
    end else if (unf_s) begin
      sum = {big_s.sign, 31'd0};
    end else begin
      sum = {big_s.sign, exp_s[7:0], man_s};
    end
  end

endmodule

// File: rtl/fp_accumulator.sv
// fp_accumulator: streaming single-precision dot-product accumulator.
//   clk, reset_n (async active-low), clear (sync soft clear)
//   bus.in_*  : one product beat per cycle, in_last marks the final element
//   bus.out_* : vector sum and saturating element count, held until out_ready
// Build option: define FP_ACC_RELU_EN to clamp negative non-NaN sums to +0
// before the output register.
module fp_accumulator
  import fp_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  fp_accumulator_if.slave    bus
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  acc_state_e         state_q, state_d;
  logic [31:0]        acc_q, acc_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [31:0]        out_data_q, out_data_d;
  logic [COUNT_W-1:0] out_count_q, out_count_d;
  logic               run_q, run_d;

  logic [31:0]        sum_s, res_s;
  logic [COUNT_W-1:0] cnt_inc_s;
  logic               in_ready_s, out_valid_s, accept_s;

  fp_adder u_adder (
    .a   (acc_q),
    .b   (bus.in_data),
    .sum (sum_s)
  );

  // Handshake outputs decoded from the state; ready waits one clock after reset
  always_comb begin
    case (state_q)
      ACC: begin
        in_ready_s  = run_q;
        out_valid_s = 1'b0;
      end
      HOLD: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b1;
      end
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Beat acceptance and the saturating increment of the element count
  always_comb begin
    accept_s = bus.in_valid && in_ready_s && !clear;
    if (count_q == CNT_MAX) cnt_inc_s = count_q;
    else                    cnt_inc_s = count_q + COUNT_W'(1);
  end

  // Optional ReLU on the value headed for the output register
  always_comb begin
`ifdef FP_ACC_RELU_EN
    if (sum_s[31] && !is_nan(sum_s)) res_s = FP_POS_ZERO;
    else                             res_s = sum_s;
`else
    res_s = sum_s;
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ACC;
    end else begin
      case (state_q)
        ACC: begin
          if (accept_s && bus.in_last) state_d = HOLD;
          else                         state_d = ACC;
        end
        HOLD: begin
          if (bus.out_ready) state_d = ACC;
          else               state_d = HOLD;
        end
        default: state_d = ACC;
      endcase
    end
  end

  // Datapath next values: clear, then result handoff, then accumulation
  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    run_d       = 1'b1;
    if (clear) begin
      acc_d   = FP_POS_ZERO;
      count_d = '0;
    end else if (out_valid_s && bus.out_ready) begin
      acc_d   = FP_POS_ZERO;
      count_d = '0;
    end else if (accept_s) begin
      acc_d   = sum_s;
      count_d = cnt_inc_s;
      if (bus.in_last) begin
        out_data_d  = res_s;
        out_count_d = cnt_inc_s;
      end else begin
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
      end
    end else begin
      acc_d   = acc_q;
      count_d = count_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ACC;
    else          state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= FP_POS_ZERO;
      count_q     <= '0;
      out_data_q  <= FP_POS_ZERO;
      out_count_q <= '0;
      run_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      run_q       <= run_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_fp_accumulator.sv
// tb_fp_accumulator: table-driven and randomized self-checking bench for
// fp_accumulator, with a plain-arithmetic reference model of the sum.
module tb_fp_accumulator;

  localparam int CW     = 4;
  localparam int CNTMAX = 15;

  logic clk = 1'b0;
  logic reset_n;
  logic clear;
  int   total = 0;
  int   bad   = 0;

  fp_accumulator_if #(.COUNT_W(CW)) bus ();

  fp_accumulator #(.COUNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] sum;
  } vec_t;

  // Reference: value-level addition following the documented rounding rules
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    int     ea, eb, el, es, diff, e;
    longint va, vb, vl, vs, r;
    bit     sl, ss;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    va = longint'(a[22:0]); vb = longint'(b[22:0]);
    if ((ea == 255 && va != 0) || (eb == 255 && vb != 0)) return 32'h7FC00000;
    if (ea == 255 && eb == 255) return (a[31] == b[31]) ? a : 32'h7FC00000;
    if (ea == 255) return a;
    if (eb == 255) return b;
    if (ea == 0 && eb == 0) return {a[31] & b[31], 31'd0};
    if (ea == 0) return b;
    if (eb == 0) return a;
    va = va + 64'd8388608; vb = vb + 64'd8388608;
    if (ea > eb || (ea == eb && va >= vb)) begin
      el = ea; vl = va; sl = a[31]; es = eb; vs = vb; ss = b[31];
    end else begin
      el = eb; vl = vb; sl = b[31]; es = ea; vs = va; ss = a[31];
    end
    diff = el - es;
    vs = (diff > 40) ? 64'd0 : vs / (64'd1 << diff);
    r  = (sl == ss) ? vl + vs : vl - vs;
    if (r == 0) return 32'h0;
    e = el;
    while (r >= 64'd16777216) begin r = r / 2; e = e + 1; end
    while (r < 64'd8388608)   begin r = r * 2; e = e - 1; end
    if (e >= 255) return {sl, 8'hFF, 23'd0};
    if (e <= 0)   return {sl, 31'd0};
    return {sl, 8'(e), 23'(r)};
  endfunction

  function automatic logic [31:0] post(input logic [31:0] x);
`ifdef FP_ACC_RELU_EN
    if (x[31] && !(x[30:23] == 8'hFF && x[22:0] != 23'd0)) return 32'h0;
`endif
    return x;
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 39);
    case (k)
      0: return 32'h7F800000;
      1: return 32'hFF800000;
      2: return 32'h7FC00001;
      3: return {r[31], 8'd0, r[22:0]};
      4: return {r[31], 8'($urandom_range(250, 254)), r[22:0]};
      default: return {r[31], 8'($urandom_range(120, 134)), r[22:0]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Called right after the last beat's edge: checks 1-cycle latency, the
  // held result, then completes the handshake
  task automatic expect_result(input string name, input logic [31:0] ed, input int ec,
                               input int hold_cyc);
    int          n;
    logic [31:0] held;
    chk({name, "/latency"}, {31'd0, bus.out_valid}, 32'd1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "/data"}, bus.out_data, ed);
    chk({name, "/count"}, 32'(bus.out_count), 32'(ec));
    held = bus.out_data;
    for (int i = 0; i < hold_cyc; i++) begin
      @(posedge clk); #1;
      chk({name, "/hold_data"}, bus.out_data, held);
      chk({name, "/hold_ready"}, {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({name, "/done_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({name, "/done_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    vec_t        tbl [12];
    logic [31:0] acc;
    logic [31:0] d;
    int          len;

    tbl[0]  = '{32'h40400000, 32'hC0400000, 32'h00000000};
    tbl[1]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
    tbl[2]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000};
    tbl[3]  = '{32'hBF800000, 32'hC0000000, 32'hC0400000};
    tbl[4]  = '{32'h3F800000, 32'h00000001, 32'h3F800000};
    tbl[5]  = '{32'h80000000, 32'h80000000, 32'h00000000};
    tbl[6]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000};
    tbl[7]  = '{32'h3F800000, 32'h33800000, 32'h3F800000};
    tbl[8]  = '{32'h3F800000, 32'hBF7FFFFF, 32'h34000000};
    tbl[9]  = '{32'h00800000, 32'h80800001, 32'h80000000};
    tbl[10] = '{32'h3FC00000, 32'h3FC00000, 32'h40400000};
    tbl[11] = '{32'hFF800000, 32'h3F800000, 32'hFF800000};

    reset_n = 1'b0; clear = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 32'h0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    #12;
    chk("rst/valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst/data", bus.out_data, 32'h0);
    chk("rst/count", 32'(bus.out_count), 32'd0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst/ready", {31'd0, bus.in_ready}, 32'd1);

    // 1 + 2 + 3 back-to-back, then a 5-cycle hold
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    send(32'h40400000, 1'b1);
    expect_result("sum123", post(32'h40C00000), 3, 5);
    // accumulator restarts from +0 right after the handshake
    send(32'h3F800000, 1'b1);
    expect_result("restart", 32'h3F800000, 1, 0);

    for (int i = 0; i < 12; i++) begin
      send(tbl[i].d0, 1'b0);
      send(tbl[i].d1, 1'b1);
      expect_result($sformatf("tbl%0d", i), post(tbl[i].sum), 2, 0);
    end

    // clear drops the partial sum and the beat presented with it
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = 32'h40400000; bus.in_last = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; clear = 1'b0;
    chk("clear/valid", {31'd0, bus.out_valid}, 32'd0);
    send(32'h3F800000, 1'b1);
    expect_result("after_clear", 32'h3F800000, 1, 0);

    // count saturates while the sum keeps growing
    for (int i = 0; i < 20; i++) send(32'h3F800000, (i == 19));
    expect_result("saturate", 32'h41A00000, CNTMAX, 0);

    // asynchronous reset between edges while a result is held
    send(32'h40400000, 1'b1);
    chk("async/pre_valid", {31'd0, bus.out_valid}, 32'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("async/valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async/data", bus.out_data, 32'h0);
    chk("async/count", 32'(bus.out_count), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("async/ready", {31'd0, bus.in_ready}, 32'd1);

    // reset mid-vector loses the partial sum with no result pulse
    send(32'h40000000, 1'b0);
    send(32'h40000000, 1'b0);
    #3 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst/novalid", {31'd0, bus.out_valid}, 32'd0);
    end
    send(32'hBF800000, 1'b0);
    send(32'hC0000000, 1'b1);
    expect_result("midrst", post(32'hC0400000), 2, 0);

    // randomized vectors against the reference model
    for (int v = 0; v < 40; v++) begin
      len = $urandom_range(1, 20);
      acc = 32'h0;
      for (int j = 0; j < len; j++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        d   = rnd_fp();
        acc = ref_add(acc, d);
        send(d, (j == len - 1));
      end
      expect_result($sformatf("rnd%0d", v), post(acc), (len > CNTMAX) ? CNTMAX : len,
                    $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
